// File: rtl/pix_adjust_ctrl.sv
// Brightness/contrast level scheduler: key presses become saturating steps with
// auto-repeat, held in shadow registers and committed only on the frame boundary.
module pix_adjust_ctrl #(
    parameter int unsigned      LVL_W       = 8,
    parameter logic [LVL_W-1:0] B_DEFAULT   = 8'd128,
    parameter logic [LVL_W-1:0] C_DEFAULT   = 8'd64,
    parameter logic [LVL_W-1:0] STEP        = 8'd4,
    parameter logic [LVL_W-1:0] LVL_MIN     = 8'd0,
    parameter logic [LVL_W-1:0] LVL_MAX     = 8'd255,
    parameter int unsigned      REPEAT_DLY  = 25000000,
    parameter int unsigned      REPEAT_RATE = 5000000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_frame_en,
    input  logic             i_sel_b,
    input  logic             i_sel_c,
    input  logic             i_inc_n,
    input  logic             i_dec_n,
    output logic [LVL_W-1:0] o_bright_lvl,
    output logic [LVL_W-1:0] o_contr_lvl,
    output logic             o_pending,
    output logic             o_commit_p
);

    localparam int unsigned CNT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DLY_RELOAD  = CNT_W'(REPEAT_DLY - 1);
    localparam logic [CNT_W-1:0] RATE_RELOAD = CNT_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2,
        ST_LOCK   = 2'd3
    } state_t;

    // One extra bit of headroom turns overflow/borrow into a plain compare.
    function automatic logic [LVL_W-1:0] f_step(input logic [LVL_W-1:0] lvl, input logic up);
        logic [LVL_W:0] sum;
        logic [LVL_W-1:0] res;
        if (up) begin
            sum = {1'b0, lvl} + {1'b0, STEP};
            if (sum > {1'b0, LVL_MAX}) begin
                res = LVL_MAX;
            end else begin
                res = sum[LVL_W-1:0];
            end
        end else begin
            sum = {1'b0, lvl} - {1'b0, STEP};
            if (sum[LVL_W] || (sum < {1'b0, LVL_MIN})) begin
                res = LVL_MIN;
            end else begin
                res = sum[LVL_W-1:0];
            end
        end
        return res;
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_req_inc;
    logic             r_req_b;
    logic             w_req_inc_nxt;
    logic             w_req_b_nxt;
    logic             w_step;
    logic [LVL_W-1:0] r_shadow_b;
    logic [LVL_W-1:0] r_shadow_c;
    logic [LVL_W-1:0] w_shadow_b_nxt;
    logic [LVL_W-1:0] w_shadow_c_nxt;
    logic [LVL_W-1:0] r_bright;
    logic [LVL_W-1:0] r_contr;
    logic             r_commit_p;

    logic w_inc_act;
    logic w_dec_act;
    logic w_any_key;
    logic w_valid;
    logic w_same_req;
    logic w_pending;
    logic w_commit;

    assign w_inc_act  = ~i_inc_n;
    assign w_dec_act  = ~i_dec_n;
    assign w_any_key  = w_inc_act | w_dec_act;
    assign w_valid    = (w_inc_act ^ w_dec_act) & (i_sel_b ^ i_sel_c);
    assign w_same_req = w_valid & (w_inc_act == r_req_inc) & (i_sel_b == r_req_b);
    assign w_pending  = (r_shadow_b != r_bright) | (r_shadow_c != r_contr);
    assign w_commit   = i_frame_en & w_pending;

    // Next-state, repeat counter and step strobe for the key FSM.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_req_inc_nxt = r_req_inc;
        w_req_b_nxt   = r_req_b;
        w_step        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_valid) begin
                    w_step        = 1'b1;
                    w_req_inc_nxt = w_inc_act;
                    w_req_b_nxt   = i_sel_b;
                    w_cnt_nxt     = DLY_RELOAD;
                    w_state_nxt   = ST_DELAY;
                end else if (w_any_key) begin
                    w_state_nxt = ST_LOCK;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DELAY, ST_REPEAT: begin
                // Release is checked first so a clean release re-arms immediately.
                if (!w_any_key) begin
                    w_state_nxt = ST_IDLE;
                end else if (!w_same_req) begin
                    w_state_nxt = ST_LOCK;
                end else if (r_cnt == {CNT_W{1'b0}}) begin
                    w_step      = 1'b1;
                    w_cnt_nxt   = RATE_RELOAD;
                    w_state_nxt = ST_REPEAT;
                end else begin
                    w_cnt_nxt   = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_LOCK: begin
                if (!w_any_key) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_LOCK;
                end
            end
            default: begin
                w_state_nxt = ST_LOCK;
            end
        endcase
    end

    // Saturating step applied to whichever shadow the request selects.
    always_comb begin
        w_shadow_b_nxt = r_shadow_b;
        w_shadow_c_nxt = r_shadow_c;
        if (w_step && i_sel_b) begin
            w_shadow_b_nxt = f_step(r_shadow_b, w_inc_act);
        end else if (w_step && i_sel_c) begin
            w_shadow_c_nxt = f_step(r_shadow_c, w_inc_act);
        end else begin
            w_shadow_b_nxt = r_shadow_b;
        end
    end

    // FSM state, repeat counter and latched request.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_LOCK;
            r_cnt     <= {CNT_W{1'b0}};
            r_req_inc <= 1'b0;
            r_req_b   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_req_inc <= w_req_inc_nxt;
            r_req_b   <= w_req_b_nxt;
        end
    end

    // Shadow levels.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shadow_b <= B_DEFAULT;
            r_shadow_c <= C_DEFAULT;
        end else begin
            r_shadow_b <= w_shadow_b_nxt;
            r_shadow_c <= w_shadow_c_nxt;
        end
    end

    // Commit registers take the pre-step shadows when a step coincides with frame_en.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bright   <= B_DEFAULT;
            r_contr    <= C_DEFAULT;
            r_commit_p <= 1'b0;
        end else if (w_commit) begin
            r_bright   <= r_shadow_b;
            r_contr    <= r_shadow_c;
            r_commit_p <= 1'b1;
        end else begin
            r_commit_p <= 1'b0;
        end
    end

    assign o_bright_lvl = r_bright;
    assign o_contr_lvl  = r_contr;
    assign o_pending    = w_pending;
    assign o_commit_p   = r_commit_p;

endmodule

// File: tb/tb_pix_adjust_ctrl.sv
// Directed bench for pix_adjust_ctrl with short repeat timing (DLY=10, RATE=3).
module tb_pix_adjust_ctrl;

    logic       clk;
    logic       rst;
    logic       frame_en;
    logic       sel_b;
    logic       sel_c;
    logic       inc_n;
    logic       dec_n;
    logic [7:0] bright_lvl;
    logic [7:0] contr_lvl;
    logic       pending;
    logic       commit_p;

    int total;
    int bad;

    pix_adjust_ctrl #(
        .LVL_W(8), .B_DEFAULT(8'd128), .C_DEFAULT(8'd64), .STEP(8'd4),
        .LVL_MIN(8'd0), .LVL_MAX(8'd255), .REPEAT_DLY(10), .REPEAT_RATE(3)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_frame_en(frame_en), .i_sel_b(sel_b),
        .i_sel_c(sel_c), .i_inc_n(inc_n), .i_dec_n(dec_n),
        .o_bright_lvl(bright_lvl), .o_contr_lvl(contr_lvl),
        .o_pending(pending), .o_commit_p(commit_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame;
        frame_en = 1'b1;
        tick(1);
        frame_en = 1'b0;
    endtask

    // Hold one key for n active edges, then release both and let the FSM settle.
    task automatic hold_key(input logic inc, input int n);
        inc_n = ~inc;
        dec_n = inc;
        tick(n);
        inc_n = 1'b1;
        dec_n = 1'b1;
        tick(2);
    endtask

    task automatic test_reset;
        rst = 1'b1; frame_en = 1'b0; sel_b = 1'b0; sel_c = 1'b0; inc_n = 1'b1; dec_n = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
        total++; if (bright_lvl !== 8'd128) begin bad++; $display("FAIL reset_bright actual=%0d expected=128", bright_lvl); end
        total++; if (contr_lvl !== 8'd64) begin bad++; $display("FAIL reset_contr actual=%0d expected=64", contr_lvl); end
        total++; if (pending !== 1'b0) begin bad++; $display("FAIL reset_pending actual=%b expected=0", pending); end
        frame();
        total++; if (commit_p !== 1'b0) begin bad++; $display("FAIL reset_frame_commit actual=%b expected=0", commit_p); end
        total++; if (bright_lvl !== 8'd128) begin bad++; $display("FAIL reset_frame_bright actual=%0d expected=128", bright_lvl); end
    endtask

    task automatic test_single_step;
        sel_b = 1'b1; sel_c = 1'b0;
        hold_key(1'b1, 1);
        total++; if (pending !== 1'b1) begin bad++; $display("FAIL single_pending actual=%b expected=1", pending); end
        total++; if (bright_lvl !== 8'd128) begin bad++; $display("FAIL single_precommit actual=%0d expected=128", bright_lvl); end
        frame();
        total++; if (bright_lvl !== 8'd132) begin bad++; $display("FAIL single_bright actual=%0d expected=132", bright_lvl); end
        total++; if (commit_p !== 1'b1) begin bad++; $display("FAIL single_commit_p actual=%b expected=1", commit_p); end
        total++; if (pending !== 1'b0) begin bad++; $display("FAIL single_pending_clr actual=%b expected=0", pending); end
        tick(1);
        total++; if (commit_p !== 1'b0) begin bad++; $display("FAIL single_commit_p_width actual=%b expected=0", commit_p); end
    endtask

    task automatic test_repeat;
        sel_b = 1'b0; sel_c = 1'b1;
        hold_key(1'b0, 20);          // steps at 0,10,13,16,19 -> 64-20
        frame();
        total++; if (contr_lvl !== 8'd44) begin bad++; $display("FAIL repeat20_contr actual=%0d expected=44", contr_lvl); end
        total++; if (bright_lvl !== 8'd132) begin bad++; $display("FAIL repeat20_bright actual=%0d expected=132", bright_lvl); end
        hold_key(1'b0, 10);          // edge 10 not reached: one step
        frame();
        total++; if (contr_lvl !== 8'd40) begin bad++; $display("FAIL repeat10_contr actual=%0d expected=40", contr_lvl); end
        hold_key(1'b0, 11);          // second step on edge 10
        frame();
        total++; if (contr_lvl !== 8'd32) begin bad++; $display("FAIL repeat11_contr actual=%0d expected=32", contr_lvl); end
    endtask

    task automatic test_saturate;
        sel_b = 1'b1; sel_c = 1'b0;
        hold_key(1'b1, 95);          // 30 steps: 132 -> 252
        frame();
        total++; if (bright_lvl !== 8'd252) begin bad++; $display("FAIL sat_reach252 actual=%0d expected=252", bright_lvl); end
        hold_key(1'b1, 30);
        frame();
        total++; if (bright_lvl !== 8'd255) begin bad++; $display("FAIL sat_max actual=%0d expected=255", bright_lvl); end
        hold_key(1'b0, 194);         // 63 steps: 255 -> 3
        frame();
        total++; if (bright_lvl !== 8'd3) begin bad++; $display("FAIL sat_reach3 actual=%0d expected=3", bright_lvl); end
        hold_key(1'b0, 1);
        frame();
        total++; if (bright_lvl !== 8'd0) begin bad++; $display("FAIL sat_min actual=%0d expected=0", bright_lvl); end
        tick(1);
        hold_key(1'b0, 1);
        total++; if (pending !== 1'b0) begin bad++; $display("FAIL sat_min_pending actual=%b expected=0", pending); end
        frame();
        total++; if (commit_p !== 1'b0) begin bad++; $display("FAIL sat_min_commit_p actual=%b expected=0", commit_p); end
    endtask

    task automatic test_invalid;
        sel_b = 1'b1; sel_c = 1'b0;
        inc_n = 1'b0; dec_n = 1'b0;
        tick(5);
        dec_n = 1'b1;                // one key still held: must stay locked
        tick(5);
        total++; if (pending !== 1'b0) begin bad++; $display("FAIL inv_both_keys actual=%b expected=0", pending); end
        inc_n = 1'b1;
        tick(2);
        hold_key(1'b1, 1);
        total++; if (pending !== 1'b1) begin bad++; $display("FAIL inv_rearm actual=%b expected=1", pending); end
        frame();
        total++; if (bright_lvl !== 8'd4) begin bad++; $display("FAIL inv_rearm_bright actual=%0d expected=4", bright_lvl); end
        sel_c = 1'b1;
        hold_key(1'b1, 3);
        total++; if (pending !== 1'b0) begin bad++; $display("FAIL inv_both_sel actual=%b expected=0", pending); end
        sel_b = 1'b0; sel_c = 1'b0;
        hold_key(1'b1, 3);
        total++; if (pending !== 1'b0) begin bad++; $display("FAIL inv_no_sel actual=%b expected=0", pending); end
        sel_b = 1'b1;
        inc_n = 1'b0;
        tick(3);
        sel_b = 1'b0; sel_c = 1'b1;  // select change mid-hold locks out further steps
        tick(15);
        inc_n = 1'b1;
        tick(2);
        frame();
        total++; if (bright_lvl !== 8'd8) begin bad++; $display("FAIL inv_change_bright actual=%0d expected=8", bright_lvl); end
        total++; if (contr_lvl !== 8'd32) begin bad++; $display("FAIL inv_change_contr actual=%0d expected=32", contr_lvl); end
    endtask

    task automatic test_step_on_frame;
        sel_b = 1'b1; sel_c = 1'b0;
        hold_key(1'b1, 1);           // shadow 12, pending
        inc_n = 1'b0;
        frame_en = 1'b1;
        tick(1);
        frame_en = 1'b0;
        inc_n = 1'b1;
        total++; if (bright_lvl !== 8'd12) begin bad++; $display("FAIL sof_pre_step actual=%0d expected=12", bright_lvl); end
        total++; if (commit_p !== 1'b1) begin bad++; $display("FAIL sof_commit_p actual=%b expected=1", commit_p); end
        total++; if (pending !== 1'b1) begin bad++; $display("FAIL sof_pending actual=%b expected=1", pending); end
        tick(2);
        frame();
        total++; if (bright_lvl !== 8'd16) begin bad++; $display("FAIL sof_next_frame actual=%0d expected=16", bright_lvl); end
    endtask

    task automatic test_reset_hold;
        sel_b = 1'b1; sel_c = 1'b0;
        inc_n = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(5);
        total++; if (pending !== 1'b0) begin bad++; $display("FAIL rsthold_pending actual=%b expected=0", pending); end
        total++; if (bright_lvl !== 8'd128) begin bad++; $display("FAIL rsthold_bright actual=%0d expected=128", bright_lvl); end
        inc_n = 1'b1;
        tick(2);
        hold_key(1'b1, 1);
        frame();
        total++; if (bright_lvl !== 8'd132) begin bad++; $display("FAIL rsthold_repress actual=%0d expected=132", bright_lvl); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single_step();
        test_repeat();
        test_saturate();
        test_invalid();
        test_step_on_frame();
        test_reset_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
